buffer_load_unit: RTL and testbench
===================================

// Module: buffer_load_unit
// PURPOSE
//  Upstream loader for the set-uint copy stage. Accepts a valid/ready stream of E*FSIZE-bit words and writes them
//  to sequential addresses 0..N_ITEMS-1 of a BufferRAM write port, one word per cycle.
//  Signals completion with a 1-cycle load_done pulse. load_done drives start_set_uint of the downstream copy stage.
// PARAMETERS
//  WIDTH    logN-logE  address width; N_ITEMS = 1<<WIDTH words per load
//  DATA_W   E*FSIZE    stream/RAM word width
// PORTS
//  clk          in   1          single clock, all logic posedge
//  rst          in   1          synchronous, active-high reset
//  start        in   1          1-cycle pulse; begins a load (honoured only in IDLE)
//  abort        in   1          synchronous cancel; returns to IDLE, no load_done
//  in_valid     in   1          stream word valid
//  in_data      in   DATA_W     stream word
//  in_ready     out  1          = (state==LOAD) && !abort; combinational
//  ram_inputs   out  BufferRAMTEFsizeInputs  write port; only waddr/wdata/wren driven, other fields 0
//  load_working out  1          state != IDLE
//  load_done    out  1          1-cycle pulse, coincident with last wren
//  load_count   out  WIDTH+1    words accepted in current/last load (0..N_ITEMS)
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, counter=0, load_count=0, wren=0, waddr=0, wdata=0, load_done=0.
//    in_ready is 0 in IDLE. Reset mid-LOAD/FLUSH drops all in-flight state; no load_done.
//  - FSM IDLE -> LOAD on start. LOAD -> FLUSH on accepting word N_ITEMS-1. FLUSH -> IDLE after 1 cycle.
//    Any state -> IDLE on abort (abort has priority over start and accept).
//  - Accept = in_valid && in_ready. Write is registered, latency 1:
//    the cycle after an accept, wren=1, waddr=counter value at accept, wdata=in_data at accept.
//  - counter (WIDTH bits) increments by 1 per accept, no skip, no wrap within a load.
//    It resets to 0 on start.
//  - load_count: cleared to 0 on start, +1 per accept. Holds its value in IDLE.
//  - in_valid gaps: no write, counter holds, wren=0 that cycle. Throughput 1 word/cycle when in_valid stays high.
//  - FLUSH: in_ready=0. Final wren (waddr=N_ITEMS-1) occurs here. load_done=1 this cycle only.
//  - start while LOAD/FLUSH: ignored; counter and load_count unchanged.
//    start and abort in the same cycle: abort wins, stays IDLE.
//  - Abort during LOAD: a write registered from an accept in the previous cycle still completes.
//    No further writes. load_count keeps the partial value.
//  - All outputs except in_ready are registered.
// CONFIGURATION
//  LOAD_UNIT_CHECKSUM_EN defined:
//   - Adds output port checksum (DATA_W): XOR of all words accepted in the current load.
//   - Cleared on start and on rst. Final value is valid from the load_done cycle and held until the next start.
//  Undefined: no checksum port or logic; all other behaviour is identical.
// TESTING
//  1. rst, then start, in_valid=1 for 1024 cycles with in_data=k (WIDTH=10):
//     RAM[k]=k for all k; load_done exactly once, with waddr=1023; load_count=1024; in_ready=0 afterwards.
//  2. Same load with in_valid toggled pseudo-randomly (50%):
//     exactly 1024 wren pulses, addresses strictly 0..1023 in order; load_done with the last one.
//  3. start pulsed again at accepted word 300: ignored; next waddr=300; load completes normally.
//  4. abort when load_count=100: IDLE next cycle, load_done never asserts, load_count=100;
//     new start restarts at waddr=0.
//  5. rst asserted at accepted word 37: next cycle wren=0, in_ready=0, load_working=0, load_count=0.
//  6. CHECKSUM_EN, in_data=k except word 5 = 'hFFFF: checksum='hFFFF^5 at load_done;
//     with in_data=k for every k, checksum=0.

Source files
------------

// File: rtl/buffer_load_unit.sv
// Stream-to-BufferRAM loader: writes N_ITEMS = 1<<WIDTH words to addresses 0..N_ITEMS-1, pulses load_done.
// Optional checksum port is built only when LOAD_UNIT_CHECKSUM_EN is defined.
module buffer_load_unit #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  // Packed write port: {raddr, rden, waddr, wdata, wren}; read fields are tied to zero.
  output logic [2*WIDTH+DATA_W+1:0] ram_inputs,
  output logic                      load_working,
  output logic                      load_done,
  output logic [WIDTH:0]            load_count
`ifdef LOAD_UNIT_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]         checksum
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0]  raddr;
    logic              rden;
    logic [WIDTH-1:0]  waddr;
    logic [DATA_W-1:0] wdata;
    logic              wren;
  } ram_in_t;

  typedef enum logic [1:0] {StIdle, StLoad, StFlush} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]    count_q, count_d;
  logic              wren_q, wren_d;
  logic [WIDTH-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              accept;
  ram_in_t           ram_s;

  assign in_ready = (state_q == StLoad) && !abort;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    wren_d  = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StLoad;
            cnt_d   = '0;
            count_d = '0;
          end
        end
        StLoad: begin
          if (accept) begin
            wren_d  = 1'b1;
            waddr_d = cnt_q;
            wdata_d = in_data;
            cnt_d   = cnt_q + WIDTH'(1);
            count_d = count_q + (WIDTH+1)'(1);
            // Last word: its write and load_done land together in FLUSH.
            if (cnt_q == {WIDTH{1'b1}}) begin
              state_d = StFlush;
              done_d  = 1'b1;
            end
          end
        end
        StFlush: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      count_q <= '0;
      wren_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      wren_q  <= wren_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

`ifdef LOAD_UNIT_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (!abort && (state_q == StIdle) && start) begin
      csum_d = '0;
    end else if (accept) begin
      csum_d = csum_q ^ in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

  always_comb begin
    ram_s       = '0;
    ram_s.wren  = wren_q;
    ram_s.waddr = waddr_q;
    ram_s.wdata = wdata_q;
  end

  assign ram_inputs   = ram_s;
  assign load_working = (state_q != StIdle);
  assign load_done    = done_q;
  assign load_count   = count_q;

endmodule

// File: tb/tb_buffer_load_unit.sv
// Scoreboard bench for buffer_load_unit: driver queues expected writes, monitor pops on every wren.
module tb_buffer_load_unit;
  localparam int unsigned WIDTH   = 10;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned N_ITEMS = 1 << WIDTH;
  localparam int unsigned RAM_W   = 2 * WIDTH + DATA_W + 2;

  logic              clk = 1'b0;
  logic              rst, start, abort, in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, load_working, load_done;
  logic [RAM_W-1:0]  ram_inputs;
  logic [WIDTH:0]    load_count;
`ifdef LOAD_UNIT_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  logic              wren;
  logic [DATA_W-1:0] wdata;
  logic [WIDTH-1:0]  waddr;
  logic [WIDTH:0]    rd_fields;

  assign wren      = ram_inputs[0];
  assign wdata     = ram_inputs[DATA_W:1];
  assign waddr     = ram_inputs[DATA_W+WIDTH:DATA_W+1];
  assign rd_fields = ram_inputs[RAM_W-1:DATA_W+WIDTH+1];

  buffer_load_unit #(.WIDTH(WIDTH), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .ram_inputs   (ram_inputs),
    .load_working (load_working),
    .load_done    (load_done),
    .load_count   (load_count)
`ifdef LOAD_UNIT_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    int unsigned data;
    bit          done;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   seen_dones = 0;
  int   exp_dones = 0;
  // Reference model: 0 idle, 1 load, 2 flush
  int   m_state = 0;
  int   m_cnt = 0;
  int   m_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (load_done === 1'b1) seen_dones++;
      if (wren === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got waddr=%0d wdata=%0h, expected no write", waddr, wdata);
        end else begin
          e = sb_q.pop_front();
          chk("waddr", 64'(waddr), 64'(e.addr));
          chk("wdata", 64'(wdata), 64'(e.data));
          chk("done_with_write", 64'(load_done), 64'(e.done));
          chk("read_fields_zero", 64'(rd_fields), 64'd0);
        end
      end else if (load_done !== 1'b0 && rst === 1'b0) begin
        chk("stray_done", 64'(load_done), 64'd0);
      end
    end
  end

  // One clock of stimulus; model predicts in_ready and queues the write it implies.
  task automatic cycle(input bit v, input int unsigned d, input bit st, input bit ab);
    bit   exp_rdy, acc;
    exp_t e;
    in_valid = v;
    in_data  = d[DATA_W-1:0];
    start    = st;
    abort    = ab;
    @(negedge clk);
    exp_rdy = (m_state == 1) && !ab;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    if (acc) begin
      e.addr = m_cnt;
      e.data = d & 32'hFFFF;
      e.done = (m_cnt == N_ITEMS - 1);
      if (e.done) exp_dones++;
      sb_q.push_back(e);
    end
    if (ab) begin
      m_state = 0;
    end else if (m_state == 0) begin
      if (st) begin
        m_state = 1;
        m_cnt   = 0;
        m_count = 0;
      end
    end else if (m_state == 1) begin
      if (acc) begin
        m_count++;
        if (m_cnt == N_ITEMS - 1) m_state = 2;
        m_cnt++;
      end
    end else begin
      m_state = 0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic do_reset(input bit v);
    rst      = 1'b1;
    in_valid = v;
    start    = 1'b0;
    abort    = 1'b0;
    in_data  = '0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    m_state  = 0;
    m_cnt    = 0;
    m_count  = 0;
  endtask

  logic [15:0] lfsr = 16'hACE1;

  initial begin
    int guard;
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    do_reset(1'b0);
    do_reset(1'b0);
    chk("rst_wren", 64'(wren), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_done", 64'(load_done), 64'd0);
    chk("rst_working", 64'(load_working), 64'd0);
    chk("rst_count", 64'(load_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);

    // Full back-to-back load, in_data = k
    cycle(1'b0, 0, 1'b1, 1'b0);
    chk("working_after_start", 64'(load_working), 64'd1);
    for (int k = 0; k < int'(N_ITEMS); k++) cycle(1'b1, k, 1'b0, 1'b0);
    chk("flush_done", 64'(load_done), 64'd1);
    cycle(1'b1, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    chk("full_count", 64'(load_count), 64'd1024);
    chk("full_idle_working", 64'(load_working), 64'd0);
    chk("full_idle_in_ready", 64'(in_ready), 64'd0);
    chk("full_one_done", 64'(seen_dones), 64'd1);

    // Gappy valid, 50% pattern from an LFSR
    cycle(1'b0, 0, 1'b1, 1'b0);
    guard = 0;
    while (m_state != 0 && guard < 5000) begin
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      cycle(lfsr[0], m_cnt ^ 32'h5A5A, 1'b0, 1'b0);
      guard++;
    end
    chk("gappy_finished", 64'(m_state), 64'd0);
    chk("gappy_count", 64'(load_count), 64'd1024);

    // start re-pulsed mid-load at word 300 is ignored
    cycle(1'b0, 0, 1'b1, 1'b0);
    for (int k = 0; k < int'(N_ITEMS); k++) begin
      cycle(1'b1, k + 7, (k == 300), 1'b0);
      if (k == 300) begin
        chk("restart_ignored_count", 64'(load_count), 64'd301);
        chk("restart_ignored_working", 64'(load_working), 64'd1);
      end
    end
    cycle(1'b0, 0, 1'b0, 1'b0);
    chk("restart_count", 64'(load_count), 64'd1024);

    // Abort at load_count = 100, then restart from address 0
    cycle(1'b0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 100; k++) cycle(1'b1, k, 1'b0, 1'b0);
    chk("pre_abort_count", 64'(load_count), 64'd100);
    cycle(1'b1, 100, 1'b1, 1'b1);
    chk("abort_working", 64'(load_working), 64'd0);
    chk("abort_count", 64'(load_count), 64'd100);
    cycle(1'b1, 101, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    chk("abort_count_held", 64'(load_count), 64'd100);
    cycle(1'b0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b1, k + 16'h100, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1);
    chk("abort2_count", 64'(load_count), 64'd5);

    // Reset at accepted word 37
    cycle(1'b0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 37; k++) cycle(1'b1, k, 1'b0, 1'b0);
    do_reset(1'b1);
    in_valid = 1'b1;
    #1;
    chk("midrst_wren", 64'(wren), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_working", 64'(load_working), 64'd0);
    chk("midrst_count", 64'(load_count), 64'd0);
    cycle(1'b0, 0, 1'b0, 1'b0);

`ifdef LOAD_UNIT_CHECKSUM_EN
    chk("csum_rst", 64'(checksum), 64'd0);
    cycle(1'b0, 0, 1'b1, 1'b0);
    for (int k = 0; k < int'(N_ITEMS); k++) cycle(1'b1, (k == 5) ? 32'hFFFF : k, 1'b0, 1'b0);
    chk("csum_done_flag", 64'(load_done), 64'd1);
    chk("csum_patched", 64'(checksum), 64'hFFFA);
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    chk("csum_held", 64'(checksum), 64'hFFFA);
    cycle(1'b0, 0, 1'b1, 1'b0);
    chk("csum_cleared", 64'(checksum), 64'd0);
    for (int k = 0; k < int'(N_ITEMS); k++) cycle(1'b1, k, 1'b0, 1'b0);
    chk("csum_plain", 64'(checksum), 64'd0);
    cycle(1'b0, 0, 1'b0, 1'b0);
`endif

    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    chk("done_pulses", 64'(seen_dones), 64'(exp_dones));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
